sar_magnitude_search: RTL

- Drives the other side of the 4-bit magnitude-comparator interface. It does not consume a and b. It generates the trial operand and consumes the comparator's gt/lt/eq results.
- It runs a successive-approximation (binary) search that recovers an unknown target value, one bit per clock. The target sits on the comparator's other input.
- It is used wherever a value is only observable through a magnitude comparator, such as threshold discovery or a digital SAR loop.
- The comparator is external and purely combinational: trial is applied to its a input and the target to its b input.

---
 rtl/sar_magnitude_search.sv | 115 +++++++++++
 1 files changed

// File: rtl/sar_magnitude_search.sv
// Successive-approximation search that recovers an unknown value seen only
// through an external combinational magnitude comparator (trial on a, target on b).
module sar_magnitude_search #(
  parameter int WIDTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             a_gt_b,
  input  logic             a_lt_b,
  input  logic             a_eq_b,
  output logic [WIDTH-1:0] trial,
  output logic             busy,
  output logic             done,
  output logic             found,
  output logic             error,
  output logic [WIDTH-1:0] result
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PROBE,
    ST_DONE
  } state_t;

  localparam logic [WIDTH-1:0] MSB_MASK = WIDTH'(1) << (WIDTH - 1);
  localparam logic [WIDTH-1:0] LSB_MASK = WIDTH'(1);

  state_t           state;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] mask;
  logic [WIDTH-1:0] candidate;

  // Trial depends on registers only, so the comparator loop never closes combinationally.
  assign candidate = acc | mask;
  assign trial     = (state == ST_PROBE) ? candidate : '0;
  assign busy      = (state == ST_PROBE);

  // NOTE: all state updates use non-blocking assignments so every branch sees
  // the pre-edge values of acc and mask, matching the trial the comparator saw.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state  <= ST_IDLE;
      acc    <= '0;
      mask   <= '0;
      result <= '0;
      found  <= 1'b0;
      error  <= 1'b0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (start) begin
            acc    <= '0;
            mask   <= MSB_MASK;
            found  <= 1'b0;
            error  <= 1'b0;
            result <= '0;
            state  <= ST_PROBE;
          end
        end

        ST_PROBE: begin
          unique case ({a_gt_b, a_lt_b, a_eq_b})
            3'b001: begin
              result <= candidate;
              found  <= 1'b1;
              done   <= 1'b1;
              state  <= ST_DONE;
            end
            3'b010: begin
              acc <= candidate;
              if (mask == LSB_MASK) begin
                result <= candidate;
                found  <= 1'b1;
                done   <= 1'b1;
                state  <= ST_DONE;
              end else begin
                mask <= mask >> 1;
              end
            end
            3'b100: begin
              if (mask == LSB_MASK) begin
                result <= acc;
                found  <= 1'b1;
                done   <= 1'b1;
                state  <= ST_DONE;
              end else begin
                mask <= mask >> 1;
              end
            end
            default: begin
              // Comparator flags not one-hot: abandon the search with no result.
              error  <= 1'b1;
              found  <= 1'b0;
              result <= '0;
              done   <= 1'b1;
              state  <= ST_DONE;
            end
          endcase
        end

        ST_DONE: begin
          state <= ST_IDLE;
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
